// File: rtl/relu_maxpool.sv
// Streaming ReLU followed by a 2x2/stride-2 max-pool over a row-major conv result stream.
// A half-row line buffer carries the top-row pair maxima until the matching bottom-row pair arrives.
module relu_maxpool #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_COLS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        in_rows,
  input  logic [3:0]        in_cols,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] pool_data,
  output logic              pool_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned LB_D  = MAX_COLS / 2;
  localparam int unsigned LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            r_state;
  logic [3:0]        r_rows;
  logic [3:0]        r_cols;
  logic [3:0]        r_row;
  logic [3:0]        r_col;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_linebuf [LB_D];

  logic              w_accept;
  logic              w_last;
  logic              w_row_ok;
  logic              w_col_ok;
  logic              w_pool;
  logic [LB_AW-1:0]  w_lb_idx;
  logic [DATA_W-1:0] w_r;
  logic [DATA_W-1:0] w_hmax;
  logic [DATA_W-1:0] w_lb_rd;
  logic [DATA_W-1:0] w_vmax;

  // ReLU, then unsigned max trees for the horizontal pair and the full window
  assign w_r      = in_data[DATA_W-1] ? '0 : in_data;
  assign w_hmax   = (r_hold > w_r) ? r_hold : w_r;
  assign w_lb_idx = LB_AW'(r_col >> 1);
  assign w_lb_rd  = r_linebuf[w_lb_idx];
  assign w_vmax   = (w_lb_rd > w_hmax) ? w_lb_rd : w_hmax;

  // An odd extent leaves its final row/col index unpaired, so it is excluded from pooling
  assign w_accept = (r_state == RUN) && in_valid;
  assign w_last   = (r_row == r_rows) && (r_col == r_cols);
  assign w_row_ok = r_rows[0] || (r_row != r_rows);
  assign w_col_ok = r_cols[0] || (r_col != r_cols);
  assign w_pool   = w_accept && w_row_ok && w_col_ok;

  // Line buffer has no reset: every entry is written on a top row before the bottom row reads it
  always_ff @(posedge clk) begin
    if (w_pool && !r_row[0] && r_col[0]) begin
      r_linebuf[w_lb_idx] <= w_hmax;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rows     <= '0;
      r_cols     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_hold     <= '0;
      pool_data  <= '0;
      pool_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      pool_valid <= 1'b0;
      done       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_rows  <= in_rows;
            r_cols  <= in_cols;
            r_row   <= '0;
            r_col   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_accept) begin
            if (r_col == r_cols) begin
              r_col <= '0;
              r_row <= r_row + 4'd1;
            end else begin
              r_col <= r_col + 4'd1;
            end
            if (w_pool && !r_col[0]) begin
              r_hold <= w_r;
            end
            if (w_pool && r_row[0] && r_col[0]) begin
              pool_data  <= w_vmax;
              pool_valid <= 1'b1;
            end
            if (w_last) begin
              done    <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed bench for relu_maxpool: beats driven on the falling edge, outputs checked on the next falling edge.
module tb_relu_maxpool;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  in_rows;
  logic [3:0]  in_cols;
  logic [15:0] in_data;
  logic        in_valid;
  logic [15:0] pool_data;
  logic        pool_valid;
  logic        busy;
  logic        done;

  int          total;
  int          bad;
  logic [15:0] din [64];
  int          exp_at [64];
  logic [15:0] last_out;

  relu_maxpool #(.DATA_W(16), .MAX_COLS(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_rows    (in_rows),
    .in_cols    (in_cols),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .pool_data  (pool_data),
    .pool_valid (pool_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ramp(input int n);
    for (int k = 0; k < 64; k++) begin
      din[k]    = (k < n) ? 16'(k + 1) : 16'h0;
      exp_at[k] = -1;
    end
  endtask

  // Called on a falling edge while IDLE; optionally offers a beat alongside start
  task automatic do_start(input logic [3:0] rows, input logic [3:0] cols, input bit with_valid);
    in_rows  = rows;
    in_cols  = cols;
    start    = 1'b1;
    in_valid = with_valid;
    in_data  = 16'h7FFF;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  // Drives nb_run beats of an nb_frame-beat frame; gaps inserts two idle cycles after each beat
  task automatic run_beats(input int nb_run, input int nb_frame, input bit gaps, input int start_at);
    for (int k = 0; k < nb_run; k++) begin
      in_data  = din[k];
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      if (exp_at[k] >= 0) begin
        chk($sformatf("pv k=%0d", k), 32'(pool_valid), 32'd1);
        chk($sformatf("pd k=%0d", k), 32'(pool_data), 32'(exp_at[k]));
        last_out = 16'(exp_at[k]);
      end else begin
        chk($sformatf("pv_idle k=%0d", k), 32'(pool_valid), 32'd0);
      end
      chk($sformatf("done k=%0d", k), 32'(done), (k == nb_frame - 1) ? 32'd1 : 32'd0);
      chk($sformatf("busy k=%0d", k), 32'(busy), 32'd1);
      if (gaps && k != nb_frame - 1) begin
        for (int g = 0; g < 2; g++) begin
          if (k == start_at && g == 0) begin
            start   = 1'b1;
            in_rows = 4'd9;
            in_cols = 4'd9;
          end
          @(negedge clk);
          start = 1'b0;
          chk($sformatf("gap_pv k=%0d", k), 32'(pool_valid), 32'd0);
          chk($sformatf("gap_pd k=%0d", k), 32'(pool_data), 32'(last_out));
          chk($sformatf("gap_done k=%0d", k), 32'(done), 32'd0);
        end
      end
    end
  endtask

  task automatic end_frame(input string tag);
    @(negedge clk);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk({tag, "_done_low"}, 32'(done), 32'd0);
    chk({tag, "_pv_low"}, 32'(pool_valid), 32'd0);
    chk({tag, "_pd_hold"}, 32'(pool_data), 32'(last_out));
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    last_out = 16'h0;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_rows  = 4'd0;
    in_cols  = 4'd0;
    in_data  = 16'h0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pd", 32'(pool_data), 32'd0);
    chk("rst_pv", 32'(pool_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 4x4 ramp; the beat offered with start must be dropped
    set_ramp(16);
    exp_at[5] = 6; exp_at[7] = 8; exp_at[13] = 14; exp_at[15] = 16;
    do_start(4'd3, 4'd3, 1'b1);
    run_beats(16, 16, 1'b0, -1);
    end_frame("f4x4");

    // 3x3: only the top-left window pools
    set_ramp(9);
    exp_at[4] = 5;
    do_start(4'd2, 4'd2, 1'b0);
    run_beats(9, 9, 1'b0, -1);
    end_frame("f3x3");

    // ReLU on an all-negative window
    set_ramp(4);
    din[0] = 16'hFFFB; din[1] = 16'hFFFD; din[2] = 16'hFFFE; din[3] = 16'hFFFF;
    exp_at[3] = 0;
    do_start(4'd1, 4'd1, 1'b0);
    run_beats(4, 4, 1'b0, -1);
    end_frame("relu_neg");

    // ReLU on a mixed-sign window
    set_ramp(4);
    din[0] = 16'hFFFB; din[1] = 16'h0007; din[2] = 16'hFFFE; din[3] = 16'h0003;
    exp_at[3] = 7;
    do_start(4'd1, 4'd1, 1'b0);
    run_beats(4, 4, 1'b0, -1);
    end_frame("relu_mix");

    // Single row: nothing pools, done still pulses
    set_ramp(4);
    do_start(4'd0, 4'd3, 1'b0);
    run_beats(4, 4, 1'b0, -1);
    end_frame("f1x4");

    // Throttled 4x4 with a start pulse (and bogus geometry) mid-frame
    set_ramp(16);
    exp_at[5] = 6; exp_at[7] = 8; exp_at[13] = 14; exp_at[15] = 16;
    do_start(4'd3, 4'd3, 1'b0);
    run_beats(16, 16, 1'b1, 7);
    end_frame("throttle");

    // Async reset after beat 6 of a 4x4 frame
    set_ramp(16);
    exp_at[5] = 6;
    do_start(4'd3, 4'd3, 1'b0);
    run_beats(6, 16, 1'b0, -1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pd", 32'(pool_data), 32'd0);
    chk("mid_rst_pv", 32'(pool_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    last_out = 16'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end

    // Fresh 4x4 after reset, then start during DONE (ignored) and back-to-back 5x5
    set_ramp(16);
    exp_at[5] = 6; exp_at[7] = 8; exp_at[13] = 14; exp_at[15] = 16;
    do_start(4'd3, 4'd3, 1'b0);
    run_beats(16, 16, 1'b0, -1);
    in_rows = 4'd4;
    in_cols = 4'd4;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_ignored", 32'(busy), 32'd0);
    set_ramp(25);
    exp_at[6] = 7; exp_at[8] = 9; exp_at[16] = 17; exp_at[18] = 19;
    do_start(4'd4, 4'd4, 1'b0);
    run_beats(25, 25, 1'b0, -1);
    end_frame("f5x5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
